// File: rtl/slot_arbiter.sv
// slot_arbiter: round-robin arbiter that shares one voice datapath slot
// between N requesters. Each grant is one-hot and is held until done, until
// the requester withdraws, or until HOLD_MAX cycles have elapsed.
module slot_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 timeout
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N-1:0]       elig;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               req_held;
    logic               expire;
    logic               release_c;
    logic               forced;

    // Rotating first-set search over eligible requests, starting at ptr_q.
    always_comb begin
        elig  = req & mask;
        cand  = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Release conditions while a grant is held; done wins over expiry.
    always_comb begin
        req_held  = req[idx_q];
        expire    = (cnt_q == CNT_W'(HOLD_MAX - 1));
        release_c = done | ~req_held | expire;
        forced    = expire & ~done & req_held;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)     state_d = BUSY;
            BUSY:    if (release_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for grant, index, pointer, hold counter and timeout pulse.
    always_comb begin
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (found) begin
                    grant_d = N'(1) << sel;
                    idx_d   = sel;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_c) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + IDX_W'(1);
                    timeout_d = forced;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_slot_arbiter.sv
// tb_slot_arbiter: vector table, directed multi-cycle sequences and a
// randomized run checked against a cycle-level behavioural model.
module tb_slot_arbiter;

    localparam int unsigned HOLD_MAX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // model state: who holds the slot, for how many cycles so far, next start
    int m_valid, m_idx, m_ptr, m_held, m_to;

    always #5 clk = ~clk;

    slot_arbiter #(.N(8), .HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mask        (mask),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       done;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic et);
        chk({tag, ".grant"},       32'(grant),       32'(eg));
        chk({tag, ".grant_idx"},   32'(grant_idx),   32'(ei));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(ev));
        chk({tag, ".timeout"},     32'(timeout),     32'(et));
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic d);
        req  = r;
        mask = m;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        mask = 8'h00;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of the arbiter as described in words: a held grant lasts at
    // most HOLD_MAX cycles; an idle slot goes to the first eligible
    // requester at or after the pointer, wrapping modulo 8.
    task automatic model_step(input logic [7:0] r, input logic [7:0] m, input logic d);
        logic [7:0] elig;
        bit still;
        bit expired;
        if (m_valid != 0) begin
            still   = r[m_idx];
            expired = (m_held == int'(HOLD_MAX));
            if (d || !still || expired) begin
                m_valid = 0;
                m_ptr   = (m_idx + 1) % 8;
                m_to    = (!d && still) ? 1 : 0;
            end else begin
                m_held++;
                m_to = 0;
            end
        end else begin
            m_to = 0;
            elig = r & m;
            for (int k = 0; k < 8; k++) begin
                if (elig[(m_ptr + k) % 8]) begin
                    m_idx   = (m_ptr + k) % 8;
                    m_valid = 1;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r, m, eg;
        logic       d;

        tbl[0]  = '{8'h04, 8'hFF, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[1]  = '{8'h04, 8'hFF, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[2]  = '{8'h04, 8'hFF, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[3]  = '{8'h04, 8'hFF, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{8'h00, 8'hFF, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{8'h20, 8'hFF, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[6]  = '{8'h00, 8'hFF, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[7]  = '{8'h41, 8'hBF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[8]  = '{8'h41, 8'hBF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{8'h41, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{8'h41, 8'hFF, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[11] = '{8'h41, 8'h00, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[12] = '{8'h41, 8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0};
        tbl[13] = '{8'hFF, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[14] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0};
        tbl[15] = '{8'hFF, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[16] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};

        // single request, withdraw, mask/wrap, mask during grant
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req, tbl[i].mask, tbl[i].done);
            chk_all($sformatf("vec%0d", i), tbl[i].grant, tbl[i].idx, tbl[i].valid, tbl[i].to);
        end

        // full contention: 0..7 then 0 again, one bubble between grants
        do_reset();
        for (int g = 0; g < 9; g++) begin
            eg = 8'h01 << (g % 8);
            step(8'hFF, 8'hFF, 1'b0);
            chk_all($sformatf("rr%0d.a", g), eg, 3'(g % 8), 1'b1, 1'b0);
            step(8'hFF, 8'hFF, 1'b0);
            chk_all($sformatf("rr%0d.b", g), eg, 3'(g % 8), 1'b1, 1'b0);
            step(8'hFF, 8'hFF, 1'b1);
            chk_all($sformatf("rr%0d.drop", g), 8'h00, 3'(g % 8), 1'b0, 1'b0);
        end

        // timeout after HOLD_MAX held cycles, regrant, then done on expiry
        do_reset();
        for (int c = 1; c <= int'(HOLD_MAX); c++) begin
            step(8'h10, 8'hFF, 1'b0);
            chk_all($sformatf("hold%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
        end
        step(8'h10, 8'hFF, 1'b0);
        chk_all("timeout", 8'h00, 3'd4, 1'b0, 1'b1);
        step(8'h10, 8'hFF, 1'b0);
        chk_all("regrant", 8'h10, 3'd4, 1'b1, 1'b0);
        for (int c = 2; c <= int'(HOLD_MAX); c++) begin
            step(8'h10, 8'hFF, 1'b0);
            chk_all($sformatf("hold2_%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
        end
        step(8'h10, 8'hFF, 1'b1);
        chk_all("done_at_expiry", 8'h00, 3'd4, 1'b0, 1'b0);

        // async reset between edges while grant=0x20
        do_reset();
        step(8'h20, 8'hFF, 1'b0);
        chk_all("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step(8'hFF, 8'hFF, 1'b0);
        chk_all("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

        // randomized run against the behavioural model
        do_reset();
        r = 8'h00;
        m = 8'hFF;
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin
                if ($urandom_range(0, 3) == 0) r = 8'($urandom);
                d = ($urandom_range(0, 9) == 0);
            end else begin
                if ($urandom_range(0, 19) == 0) r = 8'($urandom);
                d = ($urandom_range(0, 29) == 0);
            end
            if ($urandom_range(0, 7) == 0) m = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            step(r, m, d);
            model_step(r, m, d);
            eg = (m_valid != 0) ? (8'h01 << m_idx) : 8'h00;
            chk_all($sformatf("rand%0d", i), eg, 3'(m_idx), 1'(m_valid), 1'(m_to));
            chk($sformatf("rand%0d.onehot0", i), 32'($onehot0(grant)), 32'd1);
            chk($sformatf("rand%0d.valid_eq", i), 32'(grant_valid), 32'(grant != 8'h00));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
